// File: rtl/bs_pkg.sv
// Shared types and constants for the navigation-message port scheduler.
package bs_pkg;

  localparam int BS_NUM_CH = 8;
  localparam int BS_MSG_AW = 6;

  typedef logic [2:0]  bs_ch_t;
  typedef logic [31:0] bs_word_t;

  // Tag travelling alongside a RAM read until its data comes back.
  typedef struct packed {
    logic   valid;
    bs_ch_t ch;
  } bs_rd_tag_t;

  // Build a read tag from its fields.
  function automatic bs_rd_tag_t bs_mk_tag(input logic valid, input bs_ch_t ch);
    bs_rd_tag_t t;
    t.valid = valid;
    t.ch    = ch;
    return t;
  endfunction

endpackage

// File: rtl/bs_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... modulo N
// and grants the first requester. N must be a power of two so the search
// index wraps by plain truncation.
module bs_rr_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         any_o
);

  logic [W-1:0] cand_s;
  logic         hit_s;

  // Walk the candidates in priority order; the first hit wins and masks the rest.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand_s         = ptr_i + W'(k);
      hit_s          = req_i[cand_s] & ~any_o;
      gnt_o[cand_s]  = gnt_o[cand_s] | hit_s;
      gnt_idx_o      = hit_s ? cand_s : gnt_idx_o;
      any_o          = any_o | hit_s;
    end
  end

endmodule

// File: rtl/bs_msg_port_sched.sv
// Single-port scheduler for the per-channel message RAM. Register-path
// writes have absolute priority (they cannot be back-pressured); otherwise
// serializer word reads are granted round-robin. Read data comes back
// tagged with its channel RAM_LAT cycles after the command.
module bs_msg_port_sched
  import bs_pkg::*;
#(
  parameter int NUM_CH  = BS_NUM_CH,
  parameter int MSG_AW  = BS_MSG_AW,
  parameter int RAM_LAT = 1            // legal range 1..3
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic                     msg_wr_en,
  input  logic [3:0]               msg_wr_strb,
  input  logic [2:0]               msg_channel,
  input  logic [7:0]               msg_offset,
  input  logic [31:0]              msg_data,
  input  logic [NUM_CH-1:0]        channel_enable,
  input  logic [NUM_CH-1:0]        rd_req,
  input  logic [NUM_CH*MSG_AW-1:0] rd_addr,
  output logic [NUM_CH-1:0]        rd_gnt,
  output logic                     rd_valid,
  output logic [2:0]               rd_channel,
  output logic [31:0]              rd_data,
  output logic                     ram_en,
  output logic [3:0]               ram_we,
  output logic [2+MSG_AW:0]        ram_addr,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int AD_W = 3 + MSG_AW;

  logic              ram_en_q,    ram_en_d;
  logic [3:0]        ram_we_q,    ram_we_d;
  logic [AD_W-1:0]   ram_addr_q,  ram_addr_d;
  bs_word_t          ram_wdata_q, ram_wdata_d;
  logic [NUM_CH-1:0] rd_gnt_q,    rd_gnt_d;
  logic [CH_W-1:0]   ptr_q,       ptr_d;
  bs_ch_t            cmd_ch_q,    cmd_ch_d;
  bs_rd_tag_t        tag_q [RAM_LAT];

  logic [NUM_CH-1:0] elig_s;
  logic [NUM_CH-1:0] arb_gnt_s;
  logic [CH_W-1:0]   arb_idx_s;
  logic              arb_any_s;
  logic [MSG_AW-1:0] rd_off_s;
  logic              unused_s;

  // The upper offset bits are don't-care; fold them so they are visibly consumed.
  assign unused_s = ^msg_offset[7:MSG_AW];

  // A channel granted on the previous edge sits out one cycle so its
  // serializer can drop or advance rd_req before it is considered again.
  assign elig_s = rd_req & channel_enable & ~rd_gnt_q;

  bs_rr_arbiter #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_arb (
    .req_i     (elig_s),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt_s),
    .gnt_idx_o (arb_idx_s),
    .any_o     (arb_any_s)
  );

  assign rd_off_s = rd_addr[arb_idx_s*MSG_AW +: MSG_AW];

  // Next-command selection: write beats read; idle cycles keep address/data stable.
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 4'b0000;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rd_gnt_d    = '0;
    ptr_d       = ptr_q;
    cmd_ch_d    = cmd_ch_q;
    if (msg_wr_en) begin
      // A zero strobe still occupies the port slot; nothing is written.
      ram_en_d    = 1'b1;
      ram_we_d    = msg_wr_strb;
      ram_addr_d  = {msg_channel, msg_offset[MSG_AW-1:0]};
      ram_wdata_d = msg_data;
    end else if (arb_any_s) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 4'b0000;
      ram_addr_d  = {bs_ch_t'(arb_idx_s), rd_off_s};
      rd_gnt_d    = arb_gnt_s;
      ptr_d       = arb_idx_s;
      cmd_ch_d    = bs_ch_t'(arb_idx_s);
    end else begin
      ram_en_d    = 1'b0;
      rd_gnt_d    = '0;
    end
  end

  // Command register: RAM port drive, grant pulse and round-robin pointer.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'b0000;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0000_0000;
      rd_gnt_q    <= '0;
      ptr_q       <= CH_W'(NUM_CH - 1);
      cmd_ch_q    <= 3'd0;
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rd_gnt_q    <= rd_gnt_d;
      ptr_q       <= ptr_d;
      cmd_ch_q    <= cmd_ch_d;
    end
  end

  // Tag shift register: the tag of the read on the port this cycle enters
  // stage 0 and surfaces at the tail together with ram_rdata.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < RAM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= bs_mk_tag(|rd_gnt_q, cmd_ch_q);
      for (int i = 1; i < RAM_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign rd_gnt     = rd_gnt_q;
  assign rd_valid   = tag_q[RAM_LAT-1].valid;
  assign rd_channel = tag_q[RAM_LAT-1].ch;
  assign rd_data    = ram_rdata;

endmodule

// File: tb/tb_bs_msg_port_sched.sv
// Bench for bs_msg_port_sched: two instances (RAM_LAT 1 and 3) share the
// same stimulus; each has its own behavioural RAM. A reference model of the
// arbitration rules predicts every command and every tagged read return.
module tb_bs_msg_port_sched;
  import bs_pkg::*;

  localparam int NCH  = 8;
  localparam int AW   = 6;
  localparam int NDUT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              msg_wr_en      = 1'b0;
  logic [3:0]        msg_wr_strb    = 4'h0;
  logic [2:0]        msg_channel    = 3'd0;
  logic [7:0]        msg_offset     = 8'h00;
  logic [31:0]       msg_data       = 32'h0;
  logic [NCH-1:0]    channel_enable = 8'h00;
  logic [NCH-1:0]    rd_req         = 8'h00;
  logic [NCH*AW-1:0] rd_addr        = '0;

  logic [7:0]  gnt_o   [NDUT];
  logic        val_o   [NDUT];
  logic [2:0]  ch_o    [NDUT];
  logic [31:0] data_o  [NDUT];
  logic        en_o    [NDUT];
  logic [3:0]  we_o    [NDUT];
  logic [8:0]  addr_o  [NDUT];
  logic [31:0] wd_o    [NDUT];
  logic [31:0] rdata_i [NDUT];

  bs_msg_port_sched #(.NUM_CH(NCH), .MSG_AW(AW), .RAM_LAT(1)) u_dut_l1 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .msg_wr_en(msg_wr_en), .msg_wr_strb(msg_wr_strb), .msg_channel(msg_channel),
    .msg_offset(msg_offset), .msg_data(msg_data),
    .channel_enable(channel_enable), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(gnt_o[0]), .rd_valid(val_o[0]), .rd_channel(ch_o[0]), .rd_data(data_o[0]),
    .ram_en(en_o[0]), .ram_we(we_o[0]), .ram_addr(addr_o[0]), .ram_wdata(wd_o[0]),
    .ram_rdata(rdata_i[0])
  );

  bs_msg_port_sched #(.NUM_CH(NCH), .MSG_AW(AW), .RAM_LAT(3)) u_dut_l3 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .msg_wr_en(msg_wr_en), .msg_wr_strb(msg_wr_strb), .msg_channel(msg_channel),
    .msg_offset(msg_offset), .msg_data(msg_data),
    .channel_enable(channel_enable), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(gnt_o[1]), .rd_valid(val_o[1]), .rd_channel(ch_o[1]), .rd_data(data_o[1]),
    .ram_en(en_o[1]), .ram_we(we_o[1]), .ram_addr(addr_o[1]), .ram_wdata(wd_o[1]),
    .ram_rdata(rdata_i[1])
  );

  // Behavioural byte-writable RAMs with a 3-stage read pipeline each.
  logic [31:0] env_mem  [NDUT][512];
  logic [31:0] env_pipe [NDUT][3];
  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (en_o[d] && we_o[d] == 4'b0000) env_pipe[d][0] <= env_mem[d][addr_o[d]];
      else                               env_pipe[d][0] <= 32'hDEAD_BEEF;
      env_pipe[d][1] <= env_pipe[d][0];
      env_pipe[d][2] <= env_pipe[d][1];
      for (int b = 0; b < 4; b++) begin
        if (en_o[d] && we_o[d][b]) env_mem[d][addr_o[d]][8*b +: 8] <= wd_o[d][8*b +: 8];
      end
    end
  end
  assign rdata_i[0] = env_pipe[0][0];
  assign rdata_i[1] = env_pipe[1][2];

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [2:0]  ch;
    logic [31:0] data;
  } exp_rd_t;

  exp_rd_t     exp_q0[$];
  exp_rd_t     exp_q1[$];
  logic [31:0] m_mem [512];
  int          m_ptr  = NCH - 1;
  logic [7:0]  m_last = 8'h00;
  int          cyc    = 0;

  logic        e_en, e_wr;
  logic [3:0]  e_we;
  logic [8:0]  e_addr;
  logic [31:0] e_wd;
  logic [7:0]  e_gnt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ptr  = NCH - 1;
    m_last = 8'h00;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Predict the command issued on the coming edge from this cycle's inputs.
  task automatic model_cmd();
    int         c;
    int         cand;
    logic [8:0] a;
    e_en = 1'b0; e_wr = 1'b0; e_we = 4'h0; e_addr = 9'h0; e_wd = 32'h0; e_gnt = 8'h00;
    if (!rst_n) begin
      model_reset();
    end else if (msg_wr_en) begin
      a = {msg_channel, msg_offset[AW-1:0]};
      e_en = 1'b1; e_wr = 1'b1; e_we = msg_wr_strb; e_addr = a; e_wd = msg_data;
      for (int b = 0; b < 4; b++)
        if (msg_wr_strb[b]) m_mem[a][8*b +: 8] = msg_data[8*b +: 8];
      m_last = 8'h00;
    end else begin
      c = -1;
      for (int k = 1; k <= NCH; k++) begin
        cand = (m_ptr + k) % NCH;
        if (c < 0 && rd_req[cand] && channel_enable[cand] && !m_last[cand]) c = cand;
      end
      if (c >= 0) begin
        a      = {3'(c), rd_addr[c*AW +: AW]};
        e_en   = 1'b1;
        e_addr = a;
        e_gnt  = 8'h01 << c;
        m_ptr  = c;
        exp_q0.push_back('{cyc + 1 + 1, 3'(c), m_mem[a]});
        exp_q1.push_back('{cyc + 1 + 3, 3'(c), m_mem[a]});
      end
      m_last = e_gnt;
    end
  endtask

  // Advance one clock and compare every instance with the model.
  task automatic step();
    exp_rd_t ex;
    logic    have;
    model_cmd();
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("gnt_d%0d", d), 64'(gnt_o[d]), 64'(e_gnt));
      check_eq($sformatf("ram_en_d%0d", d), 64'(en_o[d]), 64'(e_en));
      check_eq($sformatf("ram_we_d%0d", d), 64'(we_o[d]), 64'(e_we));
      if (e_en) check_eq($sformatf("ram_addr_d%0d", d), 64'(addr_o[d]), 64'(e_addr));
      if (e_wr) check_eq($sformatf("ram_wdata_d%0d", d), 64'(wd_o[d]), 64'(e_wd));
      have = 1'b0;
      ex   = '{0, 3'd0, 32'h0};
      if (d == 0 && exp_q0.size() > 0 && exp_q0[0].due == cyc) begin
        have = 1'b1; ex = exp_q0.pop_front();
      end else if (d == 1 && exp_q1.size() > 0 && exp_q1[0].due == cyc) begin
        have = 1'b1; ex = exp_q1.pop_front();
      end
      check_eq($sformatf("rd_valid_d%0d", d), 64'(val_o[d]), 64'(have));
      if (have) begin
        check_eq($sformatf("rd_channel_d%0d", d), 64'(ch_o[d]), 64'(ex.ch));
        check_eq($sformatf("rd_data_d%0d", d), 64'(data_o[d]), 64'(ex.data));
      end
    end
  endtask

  task automatic check_all_reset(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      check_eq({tag, "_gnt"},   64'(gnt_o[d]),  64'h0);
      check_eq({tag, "_en"},    64'(en_o[d]),   64'h0);
      check_eq({tag, "_we"},    64'(we_o[d]),   64'h0);
      check_eq({tag, "_addr"},  64'(addr_o[d]), 64'h0);
      check_eq({tag, "_wdata"}, 64'(wd_o[d]),   64'h0);
      check_eq({tag, "_valid"}, 64'(val_o[d]),  64'h0);
      check_eq({tag, "_ch"},    64'(ch_o[d]),   64'h0);
    end
  endtask

  task automatic idle_inputs();
    msg_wr_en = 1'b0; msg_wr_strb = 4'h0; rd_req = 8'h00;
  endtask

  int  gcnt [NCH];
  int  gaps;
  logic found;
  logic seen5 [NDUT];

  initial begin
    // Reset state
    #1;
    check_all_reset("por");
    step();
    step();
    rst_n = 1'b1;
    channel_enable = 8'hFF;

    // Fill every word through the write path so model and RAMs agree.
    for (int w = 0; w < 512; w++) begin
      msg_wr_en = 1'b1; msg_wr_strb = 4'hF;
      msg_channel = 3'(w >> AW); msg_offset = 8'(w % 64); msg_data = $urandom;
      step();
    end
    idle_inputs();

    // Single requester: grant every other cycle, data one cycle after grant.
    rd_req = 8'h01; rd_addr = '0; rd_addr[0 +: AW] = 6'd5;
    step();
    check_eq("t1_gnt_a", 64'(gnt_o[0]), 64'h01);
    check_eq("t1_addr",  64'(addr_o[0]), 64'h005);
    step();
    check_eq("t1_gnt_b", 64'(gnt_o[0]), 64'h00);
    check_eq("t1_valid", 64'(val_o[0]), 64'h1);
    check_eq("t1_ch",    64'(ch_o[0]),  64'h0);
    step();
    check_eq("t1_gnt_c", 64'(gnt_o[0]), 64'h01);
    for (int i = 0; i < 9; i++) step();

    // All requesting: back-to-back grants, each channel twice in 16 cycles.
    idle_inputs();
    step();
    rd_req = 8'hFF; rd_addr = {16'($urandom), $urandom};
    for (int c = 0; c < NCH; c++) gcnt[c] = 0;
    gaps = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (gnt_o[0] == 8'h00) gaps++;
      for (int c = 0; c < NCH; c++) if (gnt_o[0][c]) gcnt[c]++;
    end
    check_eq("t2_gaps", 64'(gaps), 64'd0);
    for (int c = 0; c < NCH; c++) check_eq($sformatf("t2_cnt_ch%0d", c), 64'(gcnt[c]), 64'd2);

    // Write collides with a read request: write first, grant next cycle.
    rd_req = 8'h10;
    msg_wr_en = 1'b1; msg_wr_strb = 4'b0011; msg_channel = 3'd3;
    msg_offset = 8'h12; msg_data = 32'hA5A5_1234;
    step();
    check_eq("t3_we",    64'(we_o[0]),   64'h3);
    check_eq("t3_gnt",   64'(gnt_o[0]),  64'h00);
    check_eq("t3_addr",  64'(addr_o[0]), 64'h0D2);
    check_eq("t3_wdata", 64'(wd_o[0]),   64'hA5A5_1234);
    msg_wr_en = 1'b0;
    step();
    check_eq("t3_gnt_next", 64'(gnt_o[0]), 64'h10);
    rd_req = 8'h08; rd_addr[3*AW +: AW] = 6'h12;
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // Partial enable, then disable ch5 with a read in flight.
    channel_enable = 8'hF0; rd_req = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("t4_low_gnt", 64'(gnt_o[0] & 8'h0F), 64'h0);
    end
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      step();
      found = (gnt_o[0] == 8'h20);
    end
    check_eq("t4_find_g5", 64'(found), 64'h1);
    channel_enable = 8'hD0;
    seen5[0] = 1'b0; seen5[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      for (int d = 0; d < NDUT; d++) begin
        check_eq("t4_no_g5", 64'(gnt_o[d][5]), 64'h0);
        if (val_o[d] && ch_o[d] == 3'd5) seen5[d] = 1'b1;
      end
    end
    check_eq("t4_inflight_l1", 64'(seen5[0]), 64'h1);
    check_eq("t4_inflight_l3", 64'(seen5[1]), 64'h1);

    // Randomised traffic.
    channel_enable = 8'hFF;
    for (int i = 0; i < 10000; i++) begin
      msg_wr_en   = ($urandom_range(0, 4) == 0);
      msg_wr_strb = 4'($urandom);
      msg_channel = 3'($urandom);
      msg_offset  = 8'($urandom);
      msg_data    = $urandom;
      rd_req      = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      rd_addr     = {16'($urandom), $urandom};
      if ($urandom_range(0, 99) < 3) channel_enable = 8'($urandom) | 8'h11;
      step();
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) step();
    check_eq("rand_drain_l1", 64'(exp_q0.size()), 64'd0);
    check_eq("rand_drain_l3", 64'(exp_q1.size()), 64'd0);

    // Reset with reads in flight.
    channel_enable = 8'hFF; rd_req = 8'hFF; rd_addr = {16'($urandom), $urandom};
    step();
    step();
    check_eq("t6_inflight", 64'(exp_q1.size()), 64'd2);
    rst_n = 1'b0;
    #1;
    check_all_reset("mid_rst");
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    step();
    check_eq("t6_first_gnt_l1", 64'(gnt_o[0]), 64'h01);
    check_eq("t6_first_gnt_l3", 64'(gnt_o[1]), 64'h01);
    for (int i = 0; i < 8; i++) step();
    idle_inputs();
    for (int i = 0; i < 5; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound the whole run in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/bs_msg_port_sched.md
Name: bs_msg_port_sched

Overview:
- Shares the single port of the per-channel navigation-message RAM between two sources: AXI register-path message writes (msg_wr_*) and word-read requests from the 8 channel frame serializers.
- Writes always win, because the write source has no back-pressure. Reads are granted round-robin among enabled, requesting channels.
- Read data returns tagged with its channel after a fixed latency.
- Sits between the AXI register block, the message RAM (8 × 64 × 32 bit, byte-writable) and the channel serializers.

Parameters:
- NUM_CH, 8, number of channels (power of two).
- MSG_AW, 6, word-offset width per channel.
- RAM_LAT, 1, RAM read latency in cycles, legal range 1..3.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  async active-low reset
- msg_wr_en  in  1  single-cycle write pulse from the register block
- msg_wr_strb  in  4  byte strobes
- msg_channel  in  3  target channel
- msg_offset  in  8  word offset; only [MSG_AW-1:0] is used
- msg_data  in  32  write data
- channel_enable  in  NUM_CH  per-channel enable
- rd_req  in  NUM_CH  level read request per channel
- rd_addr  in  NUM_CH*MSG_AW  flattened word offsets; channel i at [i*MSG_AW +: MSG_AW]
- rd_gnt  out  NUM_CH  one-hot grant pulse
- rd_valid  out  1  read data valid
- rd_channel  out  3  channel tag of rd_data
- rd_data  out  32  read word (equals ram_rdata)
- ram_en  out  1  RAM access enable
- ram_we  out  4  RAM byte write enables
- ram_addr  out  3+MSG_AW  {channel, offset}
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid RAM_LAT cycles after ram_en with ram_we==0

Behaviour:
- Reset: all registers are asynchronous-reset. ram_en=0, ram_we=0, rd_gnt=0, rd_valid=0, rd_channel=0, ram_addr=0, ram_wdata=0, RR pointer=NUM_CH-1, last-grant mask=0, tag pipeline cleared.
- Command outputs (ram_*, rd_gnt) are registered. Cycle N inputs produce the command on edge N+1.
- Write path: msg_wr_en=1 in cycle N gives, at edge N+1:
  - ram_en=1, ram_we=msg_wr_strb, ram_addr={msg_channel, msg_offset[MSG_AW-1:0]}, ram_wdata=msg_data;
  - rd_gnt=0; RR pointer unchanged.
- msg_wr_strb==0 with msg_wr_en=1: still consumes the slot (ram_en=1, ram_we=0); the data is discarded.
- Read eligibility for channel i in cycle N: rd_req[i] & channel_enable[i] & ~last_gnt[i]. last_gnt is the one-hot grant issued at edge N, which blocks back-to-back re-grant while the requester updates.
- Read arbitration (no write in cycle N): pick the first eligible channel searching ptr+1, ptr+2, … modulo NUM_CH. At edge N+1:
  - rd_gnt one-hot for one cycle;
  - ram_en=1, ram_we=0, ram_addr={i, rd_addr_i};
  - ptr=i.
- No eligible channel: ram_en=0, rd_gnt=0, ptr held.
- Tag pipeline: each read command pushes {valid, channel} into a RAM_LAT-deep shift register. rd_valid/rd_channel are the tail, aligned with ram_rdata. Grant-to-rd_valid latency is RAM_LAT cycles after the rd_gnt cycle.
- Throughput: at most one access per cycle. A single channel requesting continuously gets one grant every 2 cycles (last_gnt rule). Two or more channels can fill every cycle.
- Write/read ordering: port access is serialized in command order.
  - A read commanded before a write to the same word returns old data.
  - A read commanded after it returns new data.
- Disabling a channel (channel_enable[i]→0) blocks new grants only. Reads already in flight still return with rd_valid.
- Reset mid-operation discards in-flight tags; no rd_valid is produced for them.
- rd_req is never qualified by rd_addr validity; addresses wrap naturally in MSG_AW bits.

Decomposition:
- Package bs_pkg holds:
  - constants BS_NUM_CH=8, BS_MSG_AW=6;
  - typedefs bs_ch_t (logic[2:0]) and bs_word_t (logic[31:0]);
  - struct bs_rd_tag_t {valid, ch}.
- Sub-module bs_rr_arbiter (parameter N): combinational, inputs req[N] and ptr; outputs gnt one-hot, gnt_idx, any. It is reusable for a future pseudo-code buffer scheduler.

Test Plan:
- Reset, then rd_req=8'h01, channel_enable=8'hFF, rd_addr_0=5, RAM_LAT=1 → rd_gnt=8'h01 every second cycle, ram_addr=9'h005, rd_valid with rd_channel=0 one cycle after each grant.
- rd_req=8'hFF, all enabled, held 16 cycles → grants cycle 0,1,…,7,0,… with no gaps and each channel granted exactly twice.
- msg_wr_en pulse (ch 3, offset 0x12, strb 4'b0011, data 0xA5A5_1234) in the same cycle as rd_req=8'h10 → next edge: write command with ram_we=4'b0011 and no grant; the channel 4 grant follows one cycle later.
- channel_enable=8'hF0 with rd_req=8'hFF → only channels 4..7 are ever granted. Drop channel_enable[5] with a ch 5 read in flight → its rd_valid still appears, with no further ch 5 grants.
- RAM_LAT=3 with a scoreboard-model RAM and random req/write traffic for 10k cycles → every grant matches exactly one rd_valid with correct tag/data 3 cycles later, and writes are never dropped.
- Assert s_axi_aresetn low while 2 reads are in flight → all outputs reach reset values immediately; after release there are no stale rd_valid pulses and the first grant goes to channel 0.
